// File: rtl/pulse_trigger_info_reader.sv
// Drains the Pulse Trigger FIFO on request and emits a framed 32-bit stream:
// header, three words per trigger, trailer; with sequence check and starvation timeout.
module pulse_trigger_info_reader #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         readout_req,
  input  logic [23:0]  expected_trig_num,
  input  logic         fifo_valid,
  input  logic [127:0] fifo_data,
  output logic         fifo_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         readout_done,
  output logic         busy,
  output logic [15:0]  seq_err_count,
  output logic [15:0]  timeout_count
);

  localparam int unsigned CNT_W = 24;
  localparam int unsigned TMO_W = 16;
  localparam int unsigned TS_W  = 44;

  typedef enum logic [2:0] {
    IDLE, HEADER, POP, WORD0, WORD1, WORD2, TRAILER, DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   n_trig;
  logic [CNT_W-1:0]   sent;
  logic [CNT_W-1:0]   exp_num;
  logic [CNT_W-1:0]   sent_next;
  logic [CNT_W-1:0]   pop_num;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [TS_W-1:0]    ts;
  logic               mismatch_flag;
  logic               timeout_flag;
  logic               accept;
  logic               unused_fifo_bits;

  assign fifo_ready       = (state == POP);
  assign accept           = out_valid & out_ready;
  assign pop_num          = fifo_data[67:44];
  assign sent_next        = sent + 24'd1;
  assign unused_fifo_bits = ^fifo_data[127:70];

  function automatic logic [31:0] trailer_word(logic tflag, logic mflag, logic [23:0] cnt);
    return {4'hF, tflag, mflag, 2'b00, cnt};
  endfunction

  // Frame sequencer; each transition also loads the registered stream outputs of the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      n_trig        <= '0;
      sent          <= '0;
      exp_num       <= '0;
      tmo_cnt       <= '0;
      ts            <= '0;
      mismatch_flag <= 1'b0;
      timeout_flag  <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      readout_done  <= 1'b0;
      busy          <= 1'b0;
      seq_err_count <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (readout_req) begin
            n_trig        <= expected_trig_num;
            sent          <= '0;
            exp_num       <= 24'd1;
            tmo_cnt       <= '0;
            mismatch_flag <= 1'b0;
            timeout_flag  <= 1'b0;
            busy          <= 1'b1;
            out_valid     <= 1'b1;
            out_last      <= 1'b0;
            out_data      <= {4'hA, 4'h0, expected_trig_num};
            state         <= HEADER;
          end
        end
        HEADER: begin
          if (accept) begin
            if (n_trig == '0) begin
              out_data <= trailer_word(timeout_flag, mismatch_flag, sent);
              out_last <= 1'b1;
              state    <= TRAILER;
            end else begin
              out_valid <= 1'b0;
              state     <= POP;
            end
          end
        end
        POP: begin
          // A word arriving on the expiry cycle wins over the timeout.
          if (fifo_valid) begin
            ts      <= fifo_data[43:0];
            tmo_cnt <= '0;
            exp_num <= exp_num + 24'd1;
            if (pop_num != exp_num) begin
              mismatch_flag <= 1'b1;
              if (seq_err_count != 16'hFFFF) seq_err_count <= seq_err_count + 16'd1;
            end
            out_valid <= 1'b1;
            out_data  <= {4'h1, 2'b00, fifo_data[69:68], pop_num};
            state     <= WORD0;
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt      <= '0;
            timeout_flag <= 1'b1;
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
            out_valid <= 1'b1;
            out_last  <= 1'b1;
            out_data  <= trailer_word(1'b1, mismatch_flag, sent);
            state     <= TRAILER;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        WORD0: begin
          if (accept) begin
            out_data <= ts[31:0];
            state    <= WORD1;
          end
        end
        WORD1: begin
          if (accept) begin
            out_data <= {4'h3, 16'h0000, ts[43:32]};
            state    <= WORD2;
          end
        end
        WORD2: begin
          if (accept) begin
            sent <= sent_next;
            if (sent_next == n_trig) begin
              out_data <= trailer_word(timeout_flag, mismatch_flag, sent_next);
              out_last <= 1'b1;
              state    <= TRAILER;
            end else begin
              out_valid <= 1'b0;
              state     <= POP;
            end
          end
        end
        TRAILER: begin
          if (accept) begin
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            readout_done <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          readout_done <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pulse_trigger_info_reader.md
Name: pulse_trigger_info_reader

Overview:
- Drains the Pulse Trigger FIFO, which the pulse trigger receiver fills with one 128-bit word per accepted front-panel trigger.
- On a readout request from the command manager, it formats the stored trigger records into a 32-bit framed stream: header, three words per trigger, trailer.
- Checks trigger-number sequencing and guards against a starved FIFO with a timeout.
- Pulses readout_done when the frame completes. That pulse clears the receiver's trigger number and stored-burst bookkeeping.

Parameters:
- TIMEOUT_CYCLES, 4096, maximum clk cycles to wait in POP for fifo_valid before aborting the frame (1..65535).

Ports:
- clk  input  1  40 MHz TTC clock
- reset_n  input  1  asynchronous, active-low reset
- readout_req  input  1  single-cycle request to start a frame
- expected_trig_num  input  24  triggers to read; sampled on the accepted readout_req
- fifo_valid  input  1  Pulse Trigger FIFO read side has data
- fifo_data  input  128  {58'd0, trig_length[69:68], trig_num[67:44], trig_timestamp[43:0]}
- fifo_ready  output  1  pop strobe; a word transfers when fifo_valid & fifo_ready
- out_valid  output  1  stream word valid
- out_ready  input  1  downstream accepts word
- out_data  output  32  stream word
- out_last  output  1  marks the trailer word
- readout_done  output  1  one-cycle pulse after the trailer is accepted
- busy  output  1  high in every state except IDLE
- seq_err_count  output  16  saturating count of trig_num mismatches since reset
- timeout_count  output  16  saturating count of aborted frames since reset

Behaviour:
- Reset, asynchronous, while reset_n=0:
  - state=IDLE.
  - All outputs 0.
  - Internal N, sent count, expected number, frame flags, timeout counter all 0.
  - Applies mid-frame too: the frame is dropped, no trailer, no readout_done.
- fifo_ready is combinational: high only in state POP. All other outputs are registered.
- States, in order: IDLE, HEADER, POP, WORD0, WORD1, WORD2, TRAILER, DONE.
- IDLE:
  - On readout_req, latch N=expected_trig_num, sent=0, exp=1, clear the mismatch and timeout flags; go to HEADER.
  - readout_req in any other state is ignored.
- HEADER:
  - out_valid=1, out_data={4'hA, 4'h0, N}.
  - On out_ready: go to TRAILER if N==0, else go to POP.
- POP:
  - Timeout counter increments each cycle fifo_valid=0.
  - On fifo_valid: latch fifo_data[69:0], clear the timeout counter, go to WORD0.
  - Sequence check on the popped word: if trig_num != exp, set the mismatch flag and increment seq_err_count (saturate at 16'hFFFF). exp increments on every pop.
  - If the counter reaches TIMEOUT_CYCLES-1 with fifo_valid still 0: set the timeout flag, increment timeout_count (saturating), go to TRAILER.
- Trigger words:
  - WORD0 out_data = {4'h1, 2'b00, trig_length, trig_num}.
  - WORD1 out_data = timestamp[31:0].
  - WORD2 out_data = {4'h3, 16'h0000, timestamp[43:32]}.
  - Each word is held with out_valid=1 until out_ready; the state advances on out_valid & out_ready.
  - After WORD2 is accepted, sent increments. If sent+1 == N go to TRAILER, else go to POP.
- TRAILER:
  - out_data = {4'hF, timeout_flag, mismatch_flag, 2'b00, sent[23:0]}, out_last=1.
  - On out_ready go to DONE.
- DONE: readout_done=1 for exactly one cycle, then IDLE.
- Stream rules:
  - out_valid never drops, and out_data never changes, while a word is pending.
  - Back-to-back words are allowed. Minimum spacing is one bubble cycle per POP.
- Arithmetic: the 24-bit sent and exp counters wrap modulo 2^24. N=24'hFFFFFF is legal.
- Simultaneous events: a fifo_valid arriving in the same cycle the timeout expires counts as a pop; the timeout is not taken.

Test Plan:
- N=0: readout_req with expected_trig_num=0 -> header 0xA0000000, trailer 0xF0000000 with out_last=1, readout_done pulse, no fifo_ready.
- N=2, FIFO holds trig_num 1 (length 2'b10, ts 44'h123_4567_89AB) and trig_num 2 (length 2'b01, ts 0):
  - trigger 1 -> 0xA0000002, 0x12000001, 0x456789AB, 0x30000123.
  - trigger 2 -> 0x11000002, 0x00000000, 0x30000000.
  - trailer 0xF0000002.
- Sequence error: N=2, FIFO holds trig_num 1 then 3 -> seq_err_count=1, trailer 0xF4000002.
- Timeout: N=3, FIFO holds one entry, TIMEOUT_CYCLES=16 -> after 16 idle cycles in POP, trailer 0xF8000001, timeout_count=1, readout_done pulses.
- Back-pressure: out_ready toggled randomly at 30% -> out_data stable while out_valid=1 and out_ready=0; word sequence identical to the unthrottled run.
- Reset mid-frame: assert reset_n=0 during WORD1 -> all outputs 0 immediately, no readout_done; a new readout_req then produces a correct frame.
